// File: rtl/lstm_fxp_pkg.sv
// Shared types and elaboration helpers for the streaming fixed-point accumulator.
// sat_trunc saturates when ACC_SATURATE_EN is defined, otherwise it wraps.
package lstm_fxp_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_OUT   = 2'd2
    } acc_state_t;

    // Wide enough for any accumulator width accepted by the top.
    localparam int SAT_MAX_W = 64;

    typedef struct packed {
        logic                 ovf;
        logic [SAT_MAX_W-1:0] data;
    } sat_res_t;

    // Summing n elements of dw bits can never exceed dw + clog2(n) bits.
    function automatic int acc_w(input int dw, input int n);
        return dw + $clog2(n);
    endfunction

    function automatic int num_beats(input int n, input int lanes);
        return (n + lanes - 1) / lanes;
    endfunction

    function automatic int last_lanes(input int n, input int lanes);
        return n - (num_beats(n, lanes) - 1) * lanes;
    endfunction

    function automatic int beat_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    function automatic int pow2_ceil(input int n);
        return 1 << $clog2(n);
    endfunction

    // Reduce a sign-extended accumulator to dw bits; ovf is the out-of-range flag
    // in both build flavours, only the returned data differs.
    function automatic sat_res_t sat_trunc(input logic signed [SAT_MAX_W-1:0] acc,
                                           input int dw);
        logic signed [SAT_MAX_W-1:0] max_v;
        logic signed [SAT_MAX_W-1:0] min_v;
        sat_res_t                    res;
        max_v    = (64'sd1 <<< (dw - 1)) - 64'sd1;
        min_v    = -(64'sd1 <<< (dw - 1));
        res.ovf  = (acc > max_v) || (acc < min_v);
        res.data = acc;
`ifdef ACC_SATURATE_EN
        if (acc > max_v) begin
            res.data = max_v;
        end else if (acc < min_v) begin
            res.data = min_v;
        end
`endif
        return res;
    endfunction

endpackage

// File: rtl/fxp_stream_accumulator_lane_sum_tree.sv
// Combinational masked adder tree: sign-extends LANES signed elements to ACC_W
// bits, zeroes lanes whose mask bit is clear, and sums them pairwise.
module lane_sum_tree
    import lstm_fxp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 8,
    parameter int ACC_W      = 25
) (
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic [LANES-1:0]            lane_mask,
    output logic signed [ACC_W-1:0]     sum
);

    // Pad to a power of two so every tree level pairs up cleanly.
    localparam int P = pow2_ceil(LANES);

    logic signed [ACC_W-1:0] w_leaf [P];
    logic signed [ACC_W-1:0] w_node [P];

    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_leaf
            if (gi < LANES) begin : g_real
                assign w_leaf[gi] = lane_mask[gi]
                    ? ACC_W'($signed(in_data[gi*DATA_WIDTH +: DATA_WIDTH]))
                    : '0;
            end else begin : g_pad
                assign w_leaf[gi] = '0;
            end
        end
    endgenerate

    // Level s adds node i+s into node i; after log2(P) levels node 0 holds the total.
    always_comb begin
        for (int i = 0; i < P; i++) begin
            w_node[i] = w_leaf[i];
        end
        for (int s = 1; s < P; s = s * 2) begin
            for (int i = 0; i < P; i = i + 2 * s) begin
                w_node[i] = w_node[i] + w_node[i+s];
            end
        end
        sum = w_node[0];
    end

endmodule

// File: rtl/fxp_stream_accumulator.sv
// Streaming reduction of an N_IN-element signed fixed-point vector, LANES per beat.
// Define ACC_SATURATE_EN to saturate the result; otherwise it wraps to DATA_WIDTH.
module fxp_stream_accumulator
    import lstm_fxp_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8,
    parameter int N_IN        = 500,
    parameter int LANES       = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        overflow
);

    localparam int ACC_W      = acc_w(DATA_WIDTH, N_IN);
    localparam int BEATS      = num_beats(N_IN, LANES);
    localparam int LAST_LANES = last_lanes(N_IN, LANES);
    localparam int CNT_W      = beat_cnt_w(BEATS);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // Input and output share one Q format, so FRACT_WIDTH only needs to be sane.
    generate
        if (FRACT_WIDTH >= DATA_WIDTH || N_IN < 2 || LANES < 1 || ACC_W > SAT_MAX_W) begin : g_bad_cfg
            $error("fxp_stream_accumulator: unsupported parameter combination");
        end
    endgenerate

    acc_state_t              r_state;
    acc_state_t              w_state_next;
    logic [CNT_W-1:0]        r_beat_cnt;
    logic [CNT_W-1:0]        w_beat_cnt_next;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_beat_sum;
    logic signed [ACC_W-1:0] w_acc_sum;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_overflow;
    logic                    w_accept;
    logic                    w_last_beat;
    logic                    w_first_beat;
    logic [LANES-1:0]        w_lane_mask;
    sat_res_t                w_sat;

    assign out_valid = (r_state == S_OUT);
    assign out_data  = r_out_data;
    assign overflow  = r_overflow;
    assign in_ready  = !out_valid || out_ready;

    assign w_accept     = in_valid && in_ready && !clr;
    assign w_last_beat  = (r_beat_cnt == LAST_BEAT);
    // Outside ACCUM the beat counter is zero, so any accepted beat opens a new vector.
    assign w_first_beat = (r_state != S_ACCUM);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_mask
            if (gi < LAST_LANES) begin : g_always_on
                assign w_lane_mask[gi] = 1'b1;
            end else begin : g_tail
                assign w_lane_mask[gi] = !w_last_beat;
            end
        end
    endgenerate

    lane_sum_tree #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .ACC_W      (ACC_W)
    ) u_lane_sum_tree (
        .in_data   (in_data),
        .lane_mask (w_lane_mask),
        .sum       (w_beat_sum)
    );

    assign w_acc_sum = w_first_beat ? w_beat_sum : (r_acc + w_beat_sum);
    assign w_sat     = sat_trunc(SAT_MAX_W'(w_acc_sum), DATA_WIDTH);

    // Accepting a beat behaves the same from IDLE, ACCUM or a consumed OUT.
    always_comb begin
        w_state_next    = r_state;
        w_beat_cnt_next = r_beat_cnt;
        if (clr) begin
            w_state_next    = S_IDLE;
            w_beat_cnt_next = '0;
        end else if (w_accept) begin
            if (w_last_beat) begin
                w_state_next    = S_OUT;
                w_beat_cnt_next = '0;
            end else begin
                w_state_next    = S_ACCUM;
                w_beat_cnt_next = r_beat_cnt + CNT_W'(1);
            end
        end else if (r_state == S_OUT && out_ready) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_beat_cnt <= w_beat_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= w_acc_sum;
        end
    end

    // Result captured on the edge accepting the final beat; held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= '0;
            r_overflow <= 1'b0;
        end else if (w_accept && w_last_beat) begin
            r_out_data <= DATA_WIDTH'(w_sat.data);
            r_overflow <= w_sat.ovf;
        end
    end

endmodule

// File: tb/tb_fxp_stream_accumulator.sv
// Directed bench for fxp_stream_accumulator with a result scoreboard.
// Expected formatting follows ACC_SATURATE_EN when the macro is defined.
module tb_fxp_stream_accumulator;

    localparam int DW    = 16;
    localparam int FW    = 8;
    localparam int NIN   = 500;
    localparam int LN    = 8;
    localparam int BEATS = (NIN + LN - 1) / LN;
    localparam int LASTL = NIN - (BEATS - 1) * LN;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clr;
    logic [LN*DW-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            overflow;

    int              n_cmp = 0;
    int              n_err = 0;
    logic [DW:0]     sb[$];
    logic            ov_at_accept;
    logic            accepted;

    always #5 clk = ~clk;

    fxp_stream_accumulator #(
        .DATA_WIDTH  (DW),
        .FRACT_WIDTH (FW),
        .N_IN        (NIN),
        .LANES       (LN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW:0] model(input longint s);
        longint      mx = (longint'(1) << (DW - 1)) - 1;
        longint      mn = -(longint'(1) << (DW - 1));
        longint      t  = s;
        logic        ovf;
        logic [DW-1:0] d;
        ovf = (s > mx) || (s < mn);
`ifdef ACC_SATURATE_EN
        if (s > mx) t = mx;
        else if (s < mn) t = mn;
`endif
        d = t[DW-1:0];
        return {ovf, d};
    endfunction

    // Negedge sample point; also pops the scoreboard on every output handshake.
    task automatic tick();
        logic [DW:0] e;
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_result observed=%0h expected=none", out_data);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_data", {16'd0, out_data}, {16'd0, e[DW-1:0]});
                check("sb_ovf", {31'd0, overflow}, {31'd0, e[DW]});
                $display("result out_data=%h overflow=%b expected=%h/%b", out_data, overflow, e[DW-1:0], e[DW]);
            end
        end
    endtask

    task automatic cycle();
        tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [LN*DW-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int t = 0; t < 200 && !accepted; t++) begin
            tick();
            if (in_ready) begin
                ov_at_accept = out_valid;
                accepted     = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) check("beat_accept", {31'd0, accepted}, 32'd1);
    endtask

    function automatic logic [LN*DW-1:0] make_beat(input int b, input logic [DW-1:0] val,
                                                   input logic [DW-1:0] junk);
        logic [LN*DW-1:0] d;
        for (int k = 0; k < LN; k++) begin
            d[k*DW +: DW] = (b == BEATS - 1 && k >= LASTL) ? junk : val;
        end
        return d;
    endfunction

    task automatic send_vec(input logic [DW-1:0] val, input logic [DW-1:0] junk,
                            input int start_beat, input bit do_push);
        longint s;
        s = longint'(NIN) * longint'($signed(val));
        if (do_push) sb.push_back(model(s));
        for (int b = start_beat; b < BEATS; b++) begin
            drive_beat(make_beat(b, val, junk));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cycle();

        // All ones: 500 * 1 = 0x01F4, valid the cycle after the last beat.
        send_vec(16'h0001, 16'h0000, 0, 1'b1);
        check("t1_valid_before_last", {31'd0, ov_at_accept}, 32'd0);
        check("t1_valid_after_last", {31'd0, out_valid}, 32'd1);
        check("t1_data", {16'd0, out_data}, 32'h01F4);
        check("t1_ovf", {31'd0, overflow}, 32'd0);

        send_vec(16'h0100, 16'h0100, 0, 1'b1);
`ifdef ACC_SATURATE_EN
        check("t2_data", {16'd0, out_data}, 32'h7FFF);
`else
        check("t2_data", {16'd0, out_data}, 32'hF400);
`endif
        check("t2_ovf", {31'd0, overflow}, 32'd1);

        send_vec(16'hFF00, 16'hFF00, 0, 1'b1);
`ifdef ACC_SATURATE_EN
        check("t3_data", {16'd0, out_data}, 32'h8000);
`else
        check("t3_data", {16'd0, out_data}, 32'h0C00);
`endif
        check("t3_ovf", {31'd0, overflow}, 32'd1);

        // Tail lanes of the final beat carry junk that must be ignored.
        send_vec(16'h0001, 16'h7FFF, 0, 1'b1);
        check("t4_mask_data", {16'd0, out_data}, 32'h01F4);
        cycle();

        // Backpressure: result 2*500 held while out_ready is low.
        out_ready = 1'b0;
        send_vec(16'h0002, 16'h0000, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_hold_valid", {31'd0, out_valid}, 32'd1);
            check("t5_hold_data", {16'd0, out_data}, 32'h03E8);
            check("t5_hold_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        in_data   = make_beat(0, 16'h0003, 16'h0000);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        check("t5_dual_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t5_after_dual_valid", {31'd0, out_valid}, 32'd0);
        send_vec(16'h0003, 16'h0000, 1, 1'b1);
        check("t5_next_data", {16'd0, out_data}, 32'h05DC);
        cycle();

        // clr after 30 beats, beat offered alongside clr is dropped.
        for (int b = 0; b < 30; b++) drive_beat(make_beat(b, 16'h0005, 16'h0000));
        in_data  = make_beat(30, 16'h0005, 16'h0000);
        in_valid = 1'b1;
        clr      = 1'b1;
        cycle();
        clr      = 1'b0;
        in_valid = 1'b0;
        check("t6_clr_valid", {31'd0, out_valid}, 32'd0);
        send_vec(16'h0001, 16'h0000, 0, 1'b1);
        check("t6_after_clr_data", {16'd0, out_data}, 32'h01F4);
        cycle();

        // clr also drops a pending result.
        out_ready = 1'b0;
        send_vec(16'h0004, 16'h0000, 0, 1'b0);
        check("t6_pending_valid", {31'd0, out_valid}, 32'd1);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check("t6_clr_drop_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;

        // Asynchronous reset in the middle of a vector.
        for (int b = 0; b < 10; b++) drive_beat(make_beat(b, 16'h0007, 16'h0000));
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_data", {16'd0, out_data}, 32'd0);
        check("t6_rst_ovf", {31'd0, overflow}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_vec(16'h0001, 16'h0000, 0, 1'b1);
        check("t6_after_rst_data", {16'd0, out_data}, 32'h01F4);
        check("t6_after_rst_valid", {31'd0, out_valid}, 32'd1);
        cycle();
        cycle();

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fxp_stream_accumulator.md
Name: fxp_stream_accumulator

Overview:
Parametrised streaming successor to the broadcast-and-sum adder test path. It reduces an N_IN-element signed fixed-point vector to one sum, taking LANES elements per beat over a valid/ready stream. Elements are no longer presented all at once. It sits in the LSTM datapath ahead of gate activation, where it replaces wide single-cycle N_IN-input adders.

Parameters:
DATA_WIDTH, 16, bits per element and per result, signed two's complement
FRACT_WIDTH, 8, fraction bits; input and output use the same Q format, so no shift is applied
N_IN, 500, elements per vector
LANES, 8, elements accepted per beat; BEATS = ceil(N_IN/LANES); LAST_LANES = N_IN - (BEATS-1)*LANES

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous abort of the current vector
in_data  in  LANES*DATA_WIDTH  lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
in_valid  in  1  beat offered
in_ready  out  1  beat can be accepted
out_data  out  DATA_WIDTH  vector sum in Q format
out_valid  out  1  result held
out_ready  in  1  result consumed
overflow  out  1  result overflowed DATA_WIDTH range; qualified by out_valid

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, beat_cnt=0, acc=0, out_data=0, out_valid=0, overflow=0.
- Accumulator width is ACC_W = DATA_WIDTH + clog2(N_IN). It never overflows internally.
- A beat is accepted when in_valid && in_ready. Accepted beat: all lanes are sign-extended to ACC_W and summed combinationally.
  - On beat_cnt == BEATS-1, lanes >= LAST_LANES are masked to zero and their values are ignored.
  - On the first beat of a vector, acc <= beat_sum. Otherwise acc <= acc + beat_sum.
- in_ready = !out_valid || out_ready. The next vector's first beat may be accepted in the same cycle the current result is consumed.
- States:
  - IDLE: beat_cnt=0. An accepted beat goes to ACCUM, or to OUT directly if BEATS==1.
  - ACCUM: increments beat_cnt per accepted beat. Acceptance of beat BEATS-1 goes to OUT and resets beat_cnt to 0.
  - OUT: out_valid=1. On out_ready, go to IDLE, or to ACCUM if a new beat was accepted that cycle.
- Latency: out_valid rises on the clock edge that accepts the last beat, i.e. visible the cycle after that beat.
- out_data and overflow are registered on that same edge. Both stay stable while out_valid && !out_ready.
- Result formatting: truncate or saturate acc to DATA_WIDTH according to the optional feature.
- clr (checked before everything else each cycle):
  - Returns to IDLE with beat_cnt=0 and out_valid=0, and drops any pending result.
  - A beat presented in the same cycle is discarded.
- in_valid low in the middle of a vector: hold state and acc, with no timeout.
- Reset mid-vector: partial sum is lost; the first beat after reset starts a new vector.

Optional Feature:
ACC_SATURATE_EN
- Defined: if acc > 2^(DATA_WIDTH-1)-1, out_data = 0x7FFF (for DW=16); if acc < -2^(DATA_WIDTH-1), out_data = 0x8000. overflow=1 in either case, else 0.
- Undefined: out_data = acc[DATA_WIDTH-1:0] (wrap). overflow is still computed as the out-of-range flag.

Decomposition:
- Package lstm_fxp_pkg holds:
  - clog2-based ACC_W function
  - BEATS/LAST_LANES derivation functions
  - sat_trunc function (saturate-or-wrap helper, selected by the macro)
  - beat_cnt width constant
- One sub-module, lane_sum_tree: combinational masked signed LANES-input adder tree producing ACC_W bits, with the lane mask as an input.
- The top holds the FSM, the accumulator and the output register.

Test Plan:
1. N_IN=500, LANES=8, every element 0x0001, out_ready=1 -> out_data=0x01F4, overflow=0, out_valid one cycle after beat 62 is accepted.
2. Every element 0x0100 (1.0) -> with ACC_SATURATE_EN: out_data=0x7FFF, overflow=1. Without it: out_data=0xF400, overflow=1.
3. Every element 0xFF00 (-1.0) -> with ACC_SATURATE_EN: 0x8000, overflow=1. Without it: 0x0C00.
4. Masking: vector of 0x0001 with lanes 4..7 of the last beat driven 0x7FFF -> out_data=0x01F4.
5. Backpressure: out_ready low 5 cycles after result -> out_data/out_valid stable, in_ready=0. out_ready high with a new beat offered -> both handshakes happen in the same cycle, and the next result is correct.
6. clr after 30 beats, then a full 0x0001 vector -> 0x01F4. rst_n pulsed low mid-vector -> all outputs 0 immediately, and the next vector sums correctly.
